aq_mmu_sram_ctrl: RTL

AQ_MMU_SRAM_CTRL -- requirements
Module: aq_mmu_sram_ctrl

---
 rtl/aq_mmu_sram_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/aq_mmu_sram_ctrl.sv
// aq_mmu_sram_ctrl
// Front-end controller for a single-port MMU SRAM. After reset, and on
// request, it zeroes every entry with a one-entry-per-cycle sweep. While
// idle it turns read/write requests into SRAM accesses in the cycle they
// are accepted. Read data comes back on the following cycle.
`timescale 1ns/1ps

module aq_mmu_sram_ctrl #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 98
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,

   input  logic                  inv_all_req,
   output logic                  inv_all_done,
   output logic                  ctrl_busy,

   input  logic                  req_vld,
   input  logic                  req_wen,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [DATA_WIDTH-1:0] req_wmask,
   output logic                  req_rdy,

   output logic                  rsp_vld,
   output logic [DATA_WIDTH-1:0] rsp_rdata,

   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q
);

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_IDLE  = 2'd2
   } state_t;

   // The sweep ends once the counter has reached the last entry index.
   localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   sweepCnt_q, sweepCnt_d;
   logic                    invDone_q, invDone_d;
   logic                    rspPend_q, rspPend_d;
   logic                    reqRdy;
   logic                    reqAccept;

   // State, sweep counter, completion pulse and pending-read flag. All of
   // them clear at once on reset, so an in-flight sweep or read is dropped.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_q    <= ST_INIT;
         sweepCnt_q <= '0;
         invDone_q  <= 1'b0;
         rspPend_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sweepCnt_q <= sweepCnt_d;
         invDone_q  <= invDone_d;
         rspPend_q  <= rspPend_d;
      end
   end

   // Next-state logic: INIT leads straight into a sweep. A sweep lasts one
   // cycle per entry. In IDLE, an invalidate request beats any access request.
   always_comb begin
      state_d    = state_q;
      sweepCnt_d = sweepCnt_q;
      invDone_d  = 1'b0;
      reqRdy     = 1'b0;
      case (state_q)
         ST_INIT: begin
            state_d    = ST_SWEEP;
            sweepCnt_d = '0;
         end
         ST_SWEEP: begin
            sweepCnt_d = sweepCnt_q + 1'b1;
            if (sweepCnt_q == CNT_LAST) begin
               state_d   = ST_IDLE;
               invDone_d = 1'b1;
            end
         end
         ST_IDLE: begin
            if (inv_all_req) begin
               state_d    = ST_SWEEP;
               sweepCnt_d = '0;
            end else begin
               reqRdy = 1'b1;
            end
         end
         default: begin
            state_d    = ST_INIT;
            sweepCnt_d = '0;
         end
      endcase
   end

   assign reqAccept = req_vld & reqRdy;
   assign rspPend_d = reqAccept & ~req_wen;

   // SRAM port drive. A sweep writes zeros across the full width. An
   // accepted request goes to the SRAM in the same cycle. Otherwise the
   // port sits idle with every enable deasserted.
   always_comb begin
      sram_cen  = 1'b1;
      sram_gwen = 1'b1;
      sram_wen  = '1;
      sram_a    = '0;
      sram_d    = '0;
      if (state_q == ST_SWEEP) begin
         sram_cen  = 1'b0;
         sram_gwen = 1'b0;
         sram_wen  = '0;
         sram_a    = sweepCnt_q;
         sram_d    = '0;
      end else if (reqAccept) begin
         sram_cen = 1'b0;
         sram_a   = req_addr;
         if (req_wen) begin
            sram_gwen = 1'b0;
            sram_wen  = ~req_wmask;
            sram_d    = req_wdata;
         end
      end
   end

   assign req_rdy      = reqRdy;
   assign ctrl_busy    = (state_q != ST_IDLE);
   assign inv_all_done = invDone_q;
   assign rsp_vld      = rspPend_q;
   assign rsp_rdata    = rspPend_q ? sram_q : '0;

endmodule
